core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the rv32i core. It steps one instruction at a time through
//  FETCH/DECODE/EXEC/MEM/WB and drives the shared memory port, IR load, PC update and
//  register-file write enable. It sits beside the combinational instruction decoder, which
//  still supplies ALU op, sign-ext, operand and writeback-source selects.
//  This block only decides *when* state-changing strobes fire.
// PARAMETERS
//  MEM_TIMEOUT   16  max wait cycles for mem_ready in FETCH/MEM before bus error (>=1)
//  RETIRE_CNT_W  32  width of retired-instruction counter
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  opcode         in   7   instr[6:0] from instruction register
//  branch_taken   in   1   ALU compare result (1 = take branch)
//  mem_ready      in   1   memory accepts/completes the current request this cycle
//  mem_req        out  1   memory request; held until mem_ready
//  mem_we         out  1   1 = store; valid only with mem_req
//  mem_addr_sel   out  1   0 = PC (fetch), 1 = ALU result (data access)
//  ir_load        out  1   load fetched word into IR (one-cycle pulse)
//  pc_write       out  1   update PC this cycle (one-cycle pulse)
//  pc_sel         out  1   0 = PC+4, 1 = PC+imm; valid with pc_write
//  reg_write_en   out  1   register-file write strobe (one-cycle pulse)
//  retire         out  1   pulse on the last cycle of every completed instruction
//  retire_count   out  RETIRE_CNT_W  retired instructions, wraps modulo 2^W
//  halted         out  1   sticky; FSM in HALT
//  illegal_instr  out  1   sticky; halt cause = unsupported opcode
//  bus_error      out  1   sticky; halt cause = memory timeout
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, retire_count=0, wait counter=0.
//    Reset asserted mid-access drops mem_req asynchronously.
//  - Outputs are Moore-decoded from state, plus mem_ready/branch_taken where noted.
//    Nothing is registered beyond state, counters and sticky flags.
//  - IDLE: all outputs 0; next cycle -> FETCH unconditionally.
//  - FETCH: mem_req=1, mem_we=0, mem_addr_sel=0.
//    On mem_ready: ir_load=1 in the same cycle -> DECODE.
//  - DECODE: 1 cycle. OP-IMM (0010011), LOAD (0000011), STORE (0100011) and
//    BRANCH (1100011) -> EXEC. Any other opcode -> HALT with illegal_instr=1.
//  - EXEC: OP-IMM -> WB. LOAD/STORE -> MEM.
//    BRANCH: pc_write=1, pc_sel=branch_taken, retire=1 -> FETCH.
//  - MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). On mem_ready: STORE gives
//    pc_write=1, pc_sel=0, retire=1 -> FETCH; LOAD -> WB.
//  - WB: reg_write_en=1, pc_write=1, pc_sel=0, retire=1 -> FETCH.
//  - Opcode class is latched at DECODE. Later states use the latched class, not the live opcode.
//  - Handshake: mem_req, mem_we and mem_addr_sel stay stable from assertion until the
//    mem_ready cycle. mem_ready outside FETCH/MEM is ignored.
//  - Wait counter: cleared on entry to FETCH/MEM, +1 each cycle without mem_ready.
//    If it reaches MEM_TIMEOUT -> HALT, bus_error=1.
//    mem_ready in the same cycle the count hits MEM_TIMEOUT wins: the access completes, no error.
//  - HALT: all strobes 0, halted=1. Left only by reset.
//  - retire_count increments on every retire pulse; all-ones wraps to 0.
//  - Latency with zero-wait memory (mem_ready tied 1), counted from FETCH entry to retire:
//    BRANCH 3, STORE 4, OP-IMM 4, LOAD 5 cycles. Each memory wait cycle adds 1.
// STRUCTURE
//  - Shared package rv32i_pkg: opcode localparams (OPC_OP_IMM, OPC_LOAD,
//    OPC_STORE, OPC_BRANCH), seq_state_t enum {IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT}
//    and instr_class_t enum.
//  - One sub-module, mem_wait_timer: wait counter with clear/enable/expired,
//    parameterised by MEM_TIMEOUT.
// TESTING
//  1. Release reset, mem_ready=1, opcode=0010011 -> IDLE,FETCH,DECODE,EXEC,WB;
//     reg_write_en+retire in WB (cycle 5 after reset); retire_count=1.
//  2. LOAD with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles with addr_sel=1;
//     WB one cycle later; total 8 cycles FETCH->retire.
//  3. BRANCH with branch_taken=1 -> pc_write=1, pc_sel=1 in EXEC, no reg_write_en;
//     with branch_taken=0 -> pc_sel=0.
//  4. opcode=0110011 at DECODE -> HALT, illegal_instr=1, halted=1; mem_req stays 0
//     for 20 further cycles.
//  5. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error=1 after 4 wait cycles;
//     mem_ready on the 4th cycle instead -> normal DECODE, no error.
//  6. rst_n low while mem_req=1 in MEM -> mem_req drops immediately, all outputs 0,
//     retire_count=0; fresh fetch after release. RETIRE_CNT_W=2 with 5 retires -> count=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: opcode encodings, sequencer states and
// the coarse instruction classes the sequencer steps through.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } seq_state_t;

   typedef enum logic [2:0] {
      CLS_OP_IMM,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_ILLEGAL
   } instr_class_t;

   // Map a raw opcode onto the class the sequencer cares about.
   function automatic instr_class_t classify(input logic [6:0] opcode);
      instr_class_t cls;
      case (opcode)
         OPC_OP_IMM: cls = CLS_OP_IMM;
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_BRANCH: cls = CLS_BRANCH;
         default:    cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Shared memory-port handshake between the sequencer (master) and memory (slave).
interface core_sequencer_if;

   logic mem_req;       // request, held until mem_ready
   logic mem_we;        // 1 = store, meaningful only with mem_req
   logic mem_addr_sel;  // 0 = PC, 1 = ALU result
   logic mem_ready;     // memory accepts/completes the request this cycle

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; flags the wait cycle that would reach MEM_TIMEOUT.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,    // restart from zero (entry to a waiting state)
   input  logic enable,   // one more cycle spent waiting
   output logic expired   // this wait cycle brings the count to MEM_TIMEOUT
);

   localparam int                CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear has priority over counting.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign every output a
      // default first, so no path through the block leaves a latch behind.
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked blocks use non-blocking '<=' so every flop samples the
      // values from before the edge, independent of statement order.
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A mem_ready arriving in the same cycle suppresses enable, so it wins.
   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the rv32i core: decides when the memory port,
// IR load, PC update and register-file write strobes fire.
module core_sequencer
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 16,
   parameter int RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              opcode,
   input  logic                    branch_taken,
   core_sequencer_if.master        mem,
   output logic                    ir_load,
   output logic                    pc_write,
   output logic                    pc_sel,
   output logic                    reg_write_en,
   output logic                    retire,
   output logic [RETIRE_CNT_W-1:0] retire_count,
   output logic                    halted,
   output logic                    illegal_instr,
   output logic                    bus_error
);

   seq_state_t              state_q, state_d;
   instr_class_t            class_q, class_d;
   logic [RETIRE_CNT_W-1:0] retire_count_q, retire_count_d;
   logic                    illegal_q, illegal_d;
   logic                    bus_error_q, bus_error_d;

   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic in_wait;
   logic timer_expired;

   // Only FETCH and MEM wait on memory; anywhere else mem_ready is ignored.
   assign in_wait = (state_q == FETCH) || (state_q == MEM);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_wait || mem.mem_ready),
      .enable  (in_wait && !mem.mem_ready),
      .expired (timer_expired)
   );

   // Next-state, sticky-cause and Moore strobe decode.
   always_comb begin
      state_d        = state_q;
      class_d        = class_q;
      illegal_d      = illegal_q;
      bus_error_d    = bus_error_q;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr_sel   = 1'b0;
      ir_load        = 1'b0;
      pc_write       = 1'b0;
      pc_sel         = 1'b0;
      reg_write_en   = 1'b0;
      retire         = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         FETCH: begin
            mem_req = 1'b1;
            if (mem.mem_ready) begin
               ir_load = 1'b1;
               state_d = DECODE;
            end else if (timer_expired) begin
               bus_error_d = 1'b1;
               state_d     = HALT;
            end
         end

         DECODE: begin
            // The class is captured here; later states never look at opcode.
            class_d = classify(opcode);
            if (class_d == CLS_ILLEGAL) begin
               illegal_d = 1'b1;
               state_d   = HALT;
            end else begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            case (class_q)
               CLS_BRANCH: begin
                  pc_write = 1'b1;
                  pc_sel   = branch_taken;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end
               CLS_LOAD, CLS_STORE: state_d = MEM;
               default:             state_d = WB;
            endcase
         end

         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (class_q == CLS_STORE);
            if (mem.mem_ready) begin
               if (class_q == CLS_STORE) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (timer_expired) begin
               bus_error_d = 1'b1;
               state_d     = HALT;
            end
         end

         WB: begin
            reg_write_en = 1'b1;
            pc_write     = 1'b1;
            retire       = 1'b1;
            state_d      = FETCH;
         end

         HALT: begin
            state_d = HALT;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Retired-instruction counter wraps naturally at 2^RETIRE_CNT_W.
   always_comb begin
      retire_count_d = retire_count_q;
      if (retire) begin
         retire_count_d = retire_count_q + 1'b1;
      end
   end

   // State, latched class, counter and sticky halt causes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         class_q        <= CLS_OP_IMM;
         retire_count_q <= '0;
         illegal_q      <= 1'b0;
         bus_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         class_q        <= class_d;
         retire_count_q <= retire_count_d;
         illegal_q      <= illegal_d;
         bus_error_q    <= bus_error_d;
      end
   end

   assign mem.mem_req      = mem_req;
   assign mem.mem_we       = mem_we;
   assign mem.mem_addr_sel = mem_addr_sel;
   assign retire_count     = retire_count_q;
   assign halted           = (state_q == HALT);
   assign illegal_instr    = illegal_q;
   assign bus_error        = bus_error_q;

endmodule
